// File: rtl/bmp_pixel_writer.sv
// bmp_pixel_writer: serialises 24-bit BGR pixels into BMP-ordered byte writes,
// padding each row to a 4-byte boundary with zero bytes.
module bmp_pixel_writer #(
  parameter int ADDR_W = 20,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter int DIM_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [DIM_W-1:0]  width,
  input  logic [DIM_W-1:0]  height,
  input  logic              pix_valid,
  output logic              pix_ready,
  input  logic [23:0]       pix_data,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_data,
  output logic              busy,
  output logic              done
);
  typedef enum logic [2:0] {IDLE, WAIT, B1, B2, PAD, FIN} state_t;
  state_t            r_state;
  logic [DIM_W-1:0]  r_w, r_h, r_col, r_row;
  logic [15:0]       r_pix;
  logic [1:0]        r_pcnt;
  logic [ADDR_W-1:0] r_ptr;
  logic              w_we, w_last_col, w_last_row, w_pad_last;
  logic [7:0]        w_byte;
  always_comb begin
    pix_ready  = r_state == WAIT;
    w_we       = (pix_ready && pix_valid) || r_state == B1 || r_state == B2 || r_state == PAD;
    w_byte     = r_state == WAIT ? pix_data[7:0] : r_state == B1 ? r_pix[7:0] :
                 r_state == B2 ? r_pix[15:8] : 8'h00;
    w_last_col = r_col == r_w - DIM_W'(1);
    w_last_row = r_row == r_h - DIM_W'(1);
    w_pad_last = r_pcnt == r_w[1:0] - 2'd1;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= IDLE;
      r_w      <= '0;
      r_h      <= '0;
      r_col    <= '0;
      r_row    <= '0;
      r_pix    <= '0;
      r_pcnt   <= '0;
      r_ptr    <= BASE_ADDR;
      mem_we   <= 1'b0;
      mem_addr <= BASE_ADDR;
      mem_data <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      mem_we <= w_we;
      if (w_we) begin
        mem_addr <= r_ptr;
        mem_data <= w_byte;
        r_ptr    <= r_ptr + ADDR_W'(1);
      end
      case (r_state)
        IDLE: if (start) begin
          r_w     <= width;
          r_h     <= height;
          r_col   <= '0;
          r_row   <= '0;
          r_ptr   <= BASE_ADDR;
          busy    <= 1'b1;
          done    <= width == '0 || height == '0;
          r_state <= (width == '0 || height == '0) ? FIN : WAIT;
        end
        WAIT: if (pix_valid) begin
          r_pix   <= pix_data[23:8];
          r_state <= B1;
        end
        B1: r_state <= B2;
        B2: begin
          r_pcnt <= '0;
          if (!w_last_col) begin
            r_col   <= r_col + DIM_W'(1);
            r_state <= WAIT;
          end else if (r_w[1:0] != 2'd0) begin
            r_state <= PAD;
          end else if (w_last_row) begin
            r_state <= FIN;
          end else begin
            r_col   <= '0;
            r_row   <= r_row + DIM_W'(1);
            r_state <= WAIT;
          end
        end
        PAD: begin
          r_pcnt <= r_pcnt + 2'd1;
          if (w_pad_last && w_last_row) begin
            r_state <= FIN;
          end else if (w_pad_last) begin
            r_col   <= '0;
            r_row   <= r_row + DIM_W'(1);
            r_state <= WAIT;
          end
        end
        // done doubles as FIN's sub-phase: first cycle arms it, second cycle is the pulse
        FIN: begin
          done <= !done;
          if (done) begin
            busy    <= 1'b0;
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_bmp_pixel_writer.sv
// tb_bmp_pixel_writer: table of frames driven through the writer, each written
// byte checked against a scoreboard filled as pixels are accepted.
module tb_bmp_pixel_writer;
  localparam int AW = 20;
  localparam int DW = 16;
  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic [DW-1:0] width = '0;
  logic [DW-1:0] height = '0;
  logic          pix_valid = 1'b0;
  logic [23:0]   pix_data = '0;
  logic          pix_ready, mem_we, busy, done;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_data;

  always #5 clk = ~clk;

  bmp_pixel_writer #(.ADDR_W(AW), .BASE_ADDR('0), .DIM_W(DW)) dut (
    .clk(clk), .reset(reset), .start(start), .width(width), .height(height),
    .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_data(pix_data),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_data(mem_data),
    .busy(busy), .done(done)
  );

  typedef struct { logic [AW-1:0] a; logic [7:0] d; bit pad; } wr_t;
  typedef struct { int w; int h; logic [23:0] p0; logic [23:0] step; bit tog; int mid; int abort; int exp; } vec_t;

  wr_t  sb[$];
  wr_t  e;
  vec_t tbl[10];
  int   nchk = 0, nerr = 0, cyc = 0, n_wr = 0, n_done = 0, last_wr_cyc = 0;
  bit   prev_ready = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (mem_we) begin
      n_wr++;
      last_wr_cyc = cyc;
      if (sb.size() == 0) chk("unexpected_write", 32'd1, 32'd0);
      else begin
        e = sb.pop_front();
        chk("wr_addr", 32'(mem_addr), 32'(e.a));
        chk("wr_data", 32'(mem_data), 32'(e.d));
        if (e.pad) chk("ready_in_pad", 32'(prev_ready), 32'd0);
      end
    end
    if (done) n_done++;
    prev_ready = pix_ready;
  end

  task automatic check_reset_values(input string tag);
    chk({tag, "_we"}, 32'(mem_we), 0);
    chk({tag, "_addr"}, 32'(mem_addr), 0);
    chk({tag, "_data"}, 32'(mem_data), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_ready"}, 32'(pix_ready), 0);
  endtask

  task automatic run_frame(input vec_t v);
    int idx = 0, it = 0, dn0, s_cyc;
    bit ph = 1'b1, aborted = 1'b0;
    logic [23:0] px = v.p0;
    logic [AW-1:0] ea = '0;
    @(posedge clk) #1;
    width = DW'(v.w); height = DW'(v.h); start = 1'b1; n_wr = 0; dn0 = n_done;
    @(posedge clk) #1;
    start = 1'b0;
    @(negedge clk) #1;
    s_cyc = cyc;
    chk("busy_after_start", 32'(busy), 1);
    chk("ready_after_start", 32'(pix_ready), 32'(v.w != 0 && v.h != 0));
    while (idx < v.w * v.h && it < 5000 && !aborted) begin
      @(posedge clk) #1;
      pix_valid = v.tog ? ph : 1'b1;
      ph = !ph;
      pix_data = pix_valid ? px : 24'($urandom);
      start = v.mid > 0 && idx == v.mid;
      width = start ? DW'(1) : DW'(v.w);
      @(negedge clk) #1;
      if (pix_valid && pix_ready) begin
        sb.push_back('{ea, px[7:0], 1'b0});   ea = ea + 1'b1;
        sb.push_back('{ea, px[15:8], 1'b0});  ea = ea + 1'b1;
        sb.push_back('{ea, px[23:16], 1'b0}); ea = ea + 1'b1;
        if (idx % v.w == v.w - 1)
          for (int p = 0; p < v.w % 4; p++) begin
            sb.push_back('{ea, 8'h00, 1'b1}); ea = ea + 1'b1;
          end
        idx++;
        px = px + v.step;
      end
      if (v.abort > 0 && n_wr >= v.abort) aborted = 1'b1;
      it++;
    end
    start = 1'b0;
    width = DW'(v.w);
    if (aborted) begin
      reset = 1'b0;
      pix_valid = 1'b0;
      #1;
      check_reset_values("midreset");
      sb.delete();
      repeat (3) @(negedge clk);
      #1;
      chk("writes_at_reset", 32'(n_wr), 32'(v.abort));
      chk("no_done_after_reset", 32'(n_done - dn0), 0);
      @(posedge clk) #1;
      reset = 1'b1;
      return;
    end
    if (idx < v.w * v.h) chk("pix_timeout", 32'(idx), 32'(v.w * v.h));
    if (v.w * v.h > 0) begin
      @(posedge clk) #1;
      pix_valid = 1'b0;
    end
    it = 0;
    while (!done && it < 100) begin
      @(negedge clk) #1;
      it++;
    end
    chk("done_seen", 32'(done), 1);
    chk("done_latency", 32'(cyc), v.exp > 0 ? 32'(last_wr_cyc + 1) : 32'(s_cyc));
    chk("byte_count", 32'(n_wr), 32'(v.exp));
    chk("sb_empty", 32'(sb.size()), 0);
    @(negedge clk) #1;
    chk("done_pulse", 32'(done), 0);
    chk("busy_end", 32'(busy), 0);
    chk("done_count", 32'(n_done - dn0), 1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{4, 1, 24'h030201, 24'h030303, 1'b0, 0, 0, 12};
    tbl[1] = '{1, 2, 24'hAABBCC, 24'h667667, 1'b0, 0, 0, 8};
    tbl[2] = '{3, 1, 24'h000001, 24'h000001, 1'b0, 0, 0, 12};
    tbl[3] = '{4, 1, 24'h030201, 24'h030303, 1'b1, 2, 0, 12};
    tbl[4] = '{5, 0, 24'h123456, 24'h000001, 1'b0, 0, 0, 0};
    tbl[5] = '{0, 3, 24'h123456, 24'h000001, 1'b0, 0, 0, 0};
    tbl[6] = '{5, 3, 24'hABCDEF, 24'h123457, 1'b0, 0, 0, 48};
    tbl[7] = '{2, 2, 24'h102030, 24'h010101, 1'b1, 0, 0, 16};
    tbl[8] = '{8, 2, 24'hF0E0D0, 24'h0F0F0F, 1'b0, 0, 5, 0};
    tbl[9] = '{2, 1, 24'h445566, 24'h111111, 1'b0, 0, 0, 8};
    repeat (3) @(negedge clk);
    #1;
    check_reset_values("reset");
    @(posedge clk) #1;
    reset = 1'b1;
    for (int i = 0; i < 10; i++) run_frame(tbl[i]);
    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
